if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage LoongArch pipeline, sitting directly upstream of the decode stage. Holds the fetch PC, drives a synchronous-read instruction SRAM (one-cycle read latency), and delivers `{pc, inst}` to decode under a valid/allow_in handshake. Holds its instruction intact through decode back-pressure using a one-entry instruction buffer. On a taken branch or jump resolved in decode, it redirects to the target and squashes the wrong-path instruction.

## Interface
- `RESET_PC`, 32'h1c000000, address of the first instruction fetched after reset.
- `to_ID_data_width`, 64, width of the bus to decode, `{pc[31:0], inst[31:0]}`.

Ports:
- `clk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `ID_allow_in`  in  1  decode can accept an instruction this cycle.
- `br_taken`  in  1  decode's current instruction redirects the PC.
- `br_target`  in  32  redirect address, qualified by `br_taken`.
- `IF_to_ID_valid`  out  1  `to_ID_data` is valid for decode.
- `to_ID_data`  out  64  `{IF_pc, IF_inst}`.
- `inst_sram_en`  out  1  SRAM read enable.
- `inst_sram_we`  out  4  tied to 4'b0.
- `inst_sram_addr`  out  32  fetch address (equals `nextpc`).
- `inst_sram_wdata`  out  32  tied to 32'b0.
- `inst_sram_rdata`  in  32  read data, valid the cycle after the address.

## Operation
- Registers:
  - `IF_valid`, reset 0.
  - `IF_pc`, reset `RESET_PC - 4`.
  - `inst_buf[31:0]`, reset 0.
  - `inst_buf_valid`, reset 0.
  - `redirect_done`, reset 0.
  - `rdata_fresh`, reset 0; set on the cycle after an IF load.
- `eff_br = br_taken & ~redirect_done`.
- `nextpc = eff_br ? br_target : IF_pc + 4`; 32-bit add, wrap-around ignored.
- `IF_ready_go = 1`.
- `IF_allow_in = ~IF_valid | eff_br | ID_allow_in`.
- `IF_load = IF_allow_in & resetn`.
- Outputs:
  - `inst_sram_en = IF_load`.
  - `inst_sram_addr = nextpc`.
  - `IF_to_ID_valid = IF_valid & ~eff_br`; the wrong-path instruction is never presented.
- On `IF_load`:
  - `IF_pc <= nextpc`, `IF_valid <= 1`.
  - `inst_buf_valid <= 0`.
  - `rdata_fresh <= 1`.
- Otherwise, `rdata_fresh <= 0`.
- Buffer capture: when `rdata_fresh & ~IF_load`, load `inst_buf <= inst_sram_rdata` and set `inst_buf_valid <= 1`.
- `IF_inst = inst_buf_valid ? inst_buf : inst_sram_rdata`. SRAM output is never relied on after its first valid cycle.
- `redirect_done`:
  - Set when `eff_br & IF_load`.
  - Cleared when `ID_allow_in`; the branch has left decode.
  - Clear takes priority when both conditions are true.
- Squash: with `eff_br` asserted, the current IF instruction is discarded and replaced by the target fetch in the same edge, independent of `ID_allow_in`.

## Timing
- Fetch latency: address presented in cycle N; instruction is offered to decode in cycle N+1.
- Throughput: one instruction per cycle with no back-pressure.
- First fetch: the first cycle with `resetn` high issues `inst_sram_en=1`, `inst_sram_addr=RESET_PC`.
- While `resetn` is low:
  - `IF_to_ID_valid=0`, `inst_sram_en=0`, `inst_sram_addr=RESET_PC`.
  - All registers are cleared asynchronously, including mid-stream and mid-stall.
- Handshake: an instruction transfers on an edge with `IF_to_ID_valid & ID_allow_in`. While stalled, `to_ID_data` is stable.
- Branch with decode advancing (`br_taken=1`, `ID_allow_in=1`):
  - The IF instruction is squashed; decode receives a bubble.
  - The target is fetched that cycle and offered the next cycle.
- Branch with decode stalled (`br_taken` held high over several cycles):
  - Redirect happens once; `redirect_done` masks `br_taken` afterwards.
  - The target instruction waits valid in IF.
  - It transfers on the same edge the branch leaves decode.
- Simultaneous `br_taken` with a pending buffered instruction: the buffer is invalidated by the `IF_load`.

## Test plan
- Reset release with `ID_allow_in=1`:
  - First `inst_sram_addr`=0x1c000000, then 0x1c000004, 0x1c000008 on consecutive cycles.
  - `IF_to_ID_valid` rises one cycle after the first request.
- Stall: hold `ID_allow_in=0` for 3 cycles while the SRAM returns 0xdeadbeef and then garbage.
  - `to_ID_data` stays `{0x1c000004, 0xdeadbeef}`.
  - `inst_sram_en=0` throughout; no address advance.
- Branch with free decode: `br_taken=1`, `br_target=0x1c000100` for one cycle while IF holds pc 0x1c000008.
  - `IF_to_ID_valid=0` that cycle.
  - Next cycle decode sees pc 0x1c000100.
- Branch with stalled decode: `br_taken=1` for 3 cycles with `ID_allow_in=0`, target 0x1c000200.
  - Exactly one request to 0x1c000200 is issued.
  - `IF_to_ID_valid=1` with that pc; it transfers when `ID_allow_in` rises.
- Reset mid-stream: drop `resetn` asynchronously between edges.
  - `IF_to_ID_valid` and `inst_sram_en` fall immediately.
  - On release, fetch restarts at 0x1c000000.

Source files
------------

// File: rtl/if_stage_if.sv
// Bundle for the fetch stage: decode handshake, branch redirect and instruction SRAM port.
interface if_stage_if;
    logic        ID_allow_in;
    logic        br_taken;
    logic [31:0] br_target;
    logic        IF_to_ID_valid;
    logic [63:0] to_ID_data;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  ID_allow_in, br_taken, br_target, inst_sram_rdata,
        output IF_to_ID_valid, to_ID_data, inst_sram_en, inst_sram_we,
               inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output ID_allow_in, br_taken, br_target, inst_sram_rdata,
        input  IF_to_ID_valid, to_ID_data, inst_sram_en, inst_sram_we,
               inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, one-cycle SRAM fetch, one-entry hold buffer
// for decode back-pressure, and single-shot redirect on taken branches.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic          clk,
    input  logic          resetn,
    if_stage_if.master    bus
);
    localparam int unsigned PC_W    = 32;
    localparam int unsigned TO_ID_W = 64;

    logic [PC_W-1:0] r_if_pc;
    logic [PC_W-1:0] r_inst_buf;
    logic            r_if_valid;
    logic            r_inst_buf_valid;
    logic            r_redirect_done;
    logic            r_rdata_fresh;

    logic            w_eff_br;
    logic            w_if_allow_in;
    logic            w_if_load;
    logic [PC_W-1:0] w_nextpc;
    logic [PC_W-1:0] w_if_inst;

    // A branch held in a stalled decode redirects only once.
    assign w_eff_br      = bus.br_taken & ~r_redirect_done;
    assign w_nextpc      = w_eff_br ? bus.br_target : r_if_pc + PC_W'(4);
    assign w_if_allow_in = ~r_if_valid | w_eff_br | bus.ID_allow_in;
    assign w_if_load     = w_if_allow_in & resetn;
    assign w_if_inst     = r_inst_buf_valid ? r_inst_buf : bus.inst_sram_rdata;

    assign bus.inst_sram_en    = w_if_load;
    assign bus.inst_sram_addr  = w_nextpc;
    assign bus.inst_sram_we    = 4'b0;
    assign bus.inst_sram_wdata = 32'b0;
    assign bus.IF_to_ID_valid  = r_if_valid & ~w_eff_br;
    assign bus.to_ID_data      = TO_ID_W'({r_if_pc, w_if_inst});

    // PC / valid / fetch-freshness tracking
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_if_pc       <= RESET_PC - PC_W'(4);
            r_if_valid    <= 1'b0;
            r_rdata_fresh <= 1'b0;
        end else begin
            r_rdata_fresh <= w_if_load;
            if (w_if_load) begin
                r_if_pc    <= w_nextpc;
                r_if_valid <= 1'b1;
            end
        end
    end

    // Capture SRAM data on its only trustworthy cycle when IF is stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_inst_buf       <= '0;
            r_inst_buf_valid <= 1'b0;
        end else if (w_if_load) begin
            r_inst_buf_valid <= 1'b0;
        end else if (r_rdata_fresh) begin
            r_inst_buf       <= bus.inst_sram_rdata;
            r_inst_buf_valid <= 1'b1;
        end
    end

    // Cleared once the branch leaves decode; clear wins over set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_redirect_done <= 1'b0;
        end else if (bus.ID_allow_in) begin
            r_redirect_done <= 1'b0;
        end else if (w_eff_br & w_if_load) begin
            r_redirect_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch/stall/branch/reset scenarios plus random traffic
// checked against a fetch-order model and an addressed instruction memory.
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    if_stage_if bus ();

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_req    = 0;

    // Model: which instruction sits in IF, and whether the live branch has been serviced.
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_served;

    logic        o_valid;
    logic        o_en;
    logic [31:0] o_addr;
    logic [63:0] o_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1c00_0004) return 32'hdead_beef;
        return {a[15:0], a[31:16]} ^ 32'h5eed_1234;
    endfunction

    // SRAM model: data only meaningful the cycle after a read, garbage otherwise.
    always @(posedge clk)
        bus.inst_sram_rdata <= bus.inst_sram_en ? mem_word(bus.inst_sram_addr) : $urandom;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_pc     = RESET_PC - 32'd4;
        m_served = 1'b0;
    endtask

    // One clock: drive inputs, check at negedge against model, advance model past posedge.
    task automatic cycle(input logic allow, input logic br, input logic [31:0] tgt);
        logic        eff;
        logic        e_valid;
        logic        e_en;
        logic [31:0] e_addr;
        bus.ID_allow_in = allow;
        bus.br_taken    = br;
        bus.br_target   = tgt;
        eff     = br & ~m_served;
        e_valid = resetn & m_valid & ~eff;
        e_en    = resetn & (~m_valid | eff | allow);
        e_addr  = eff ? tgt : m_pc + 32'd4;
        @(negedge clk);
        o_valid = bus.IF_to_ID_valid;
        o_en    = bus.inst_sram_en;
        o_addr  = bus.inst_sram_addr;
        o_data  = bus.to_ID_data;
        check("valid", 64'(o_valid), 64'(e_valid));
        check("sram_en", 64'(o_en), 64'(e_en));
        check("sram_addr", 64'(o_addr), 64'(e_addr));
        check("sram_we", 64'(bus.inst_sram_we), 64'd0);
        check("sram_wdata", 64'(bus.inst_sram_wdata), 64'd0);
        if (e_valid) check("to_id_data", o_data, {m_pc, mem_word(m_pc)});
        @(posedge clk);
        #1;
        if (resetn) begin
            if (e_en) begin
                m_pc    = e_addr;
                m_valid = 1'b1;
            end
            m_served = allow ? 1'b0 : (m_served | (eff & e_en));
        end
    endtask

    initial begin
        resetn          = 1'b0;
        bus.ID_allow_in = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 32'd0;
        model_reset();

        cycle(1'b1, 1'b0, 32'd0);
        check("rst_addr", 64'(o_addr), 64'(RESET_PC));
        check("rst_en", 64'(o_en), 64'd0);
        cycle(1'b1, 1'b0, 32'd0);
        resetn = 1'b1;

        cycle(1'b1, 1'b0, 32'd0);
        check("first_addr", 64'(o_addr), 64'h1c00_0000);
        check("first_en", 64'(o_en), 64'd1);
        check("first_valid", 64'(o_valid), 64'd0);
        cycle(1'b1, 1'b0, 32'd0);
        check("second_addr", 64'(o_addr), 64'h1c00_0004);
        check("second_valid", 64'(o_valid), 64'd1);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'd0);
            check("stall_data", o_data, 64'h1c00_0004_dead_beef);
            check("stall_en", 64'(o_en), 64'd0);
            check("stall_addr", 64'(o_addr), 64'h1c00_0008);
        end
        cycle(1'b1, 1'b0, 32'd0);
        check("release_data", o_data, 64'h1c00_0004_dead_beef);

        cycle(1'b1, 1'b1, 32'h1c00_0100);
        check("br_squash", 64'(o_valid), 64'd0);
        check("br_addr", 64'(o_addr), 64'h1c00_0100);
        cycle(1'b1, 1'b0, 32'd0);
        check("br_target_pc", 64'(o_data[63:32]), 64'h1c00_0100);

        n_req = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 32'h1c00_0200);
            if (o_en && o_addr == 32'h1c00_0200) n_req++;
        end
        check("stall_br_valid", 64'(o_valid), 64'd1);
        cycle(1'b1, 1'b1, 32'h1c00_0200);
        if (o_en && o_addr == 32'h1c00_0200) n_req++;
        check("stall_br_pc", 64'(o_data[63:32]), 64'h1c00_0200);
        check("stall_br_reqs", 64'(n_req), 64'd1);
        cycle(1'b1, 1'b0, 32'd0);

        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(3, 0) != 0), 1'($urandom_range(5, 0) == 0),
                  RESET_PC | ($urandom & 32'h0000_0ffc));

        // Asynchronous reset while stalled, between clock edges.
        bus.ID_allow_in = 1'b0;
        bus.br_taken    = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("async_valid", 64'(bus.IF_to_ID_valid), 64'd0);
        check("async_en", 64'(bus.inst_sram_en), 64'd0);
        check("async_addr", 64'(bus.inst_sram_addr), 64'(RESET_PC));
        model_reset();
        cycle(1'b1, 1'b0, 32'd0);
        #2;
        resetn = 1'b1;
        cycle(1'b1, 1'b0, 32'd0);
        check("restart_addr", 64'(o_addr), 64'(RESET_PC));
        check("restart_en", 64'(o_en), 64'd1);
        cycle(1'b1, 1'b0, 32'd0);
        check("restart_pc", 64'(o_data[63:32]), 64'(RESET_PC));

        for (int i = 0; i < 200; i++)
            cycle(1'($urandom_range(3, 0) != 0), 1'($urandom_range(5, 0) == 0),
                  RESET_PC | ($urandom & 32'h0000_0ffc));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
